hash_work_sched: RTL and testbench

HASH_WORK_SCHED -- requirements
Module: hash_work_sched

---
 rtl/hash_sched_pkg.sv | 14 +
 rtl/hash_result_fifo.sv | 41 ++++
 rtl/hash_work_sched.sv | 108 ++++++++++
 tb/tb_hash_work_sched.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/hash_sched_pkg.sv
// hash_sched_pkg: shared widths, state encoding and defaults for the hash work scheduler.
package hash_sched_pkg;
  localparam int NONCE_W        = 32;
  localparam int ID_W           = 8;
  localparam int CNT_W          = 32;
  localparam int DROP_W         = 8;
  localparam int RES_W          = NONCE_W + ID_W;
  localparam int PIPE_DEPTH_DEF = 130;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;
endpackage

// File: rtl/hash_result_fifo.sv
// hash_result_fifo: registered-output result FIFO; a full FIFO accepts a push only alongside a pop.
module hash_result_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 40
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic             o_valid,
  output logic             o_full,
  output logic [WIDTH-1:0] o_data
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wp, r_rp;
  logic [CW-1:0]    r_cnt;
  logic             w_push, w_pop;
  assign o_valid = r_cnt != '0;
  assign o_full  = r_cnt == CW'(DEPTH);
  assign w_pop   = i_pop & o_valid;
  assign w_push  = i_push & (~o_full | w_pop);
  // Head is masked so the outputs read zero whenever the FIFO is empty, including reset.
  assign o_data  = o_valid ? r_mem[r_rp] : '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= (r_wp == AW'(DEPTH - 1)) ? '0 : r_wp + 1'b1;
      if (w_pop)  r_rp <= (r_rp == AW'(DEPTH - 1)) ? '0 : r_rp + 1'b1;
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= i_data;
  end
endmodule

// File: rtl/hash_work_sched.sv
// hash_work_sched: feeds work and nonces to a pipelined hash core and tags returning
// matches with the work unit that produced them.
module hash_work_sched
  import hash_sched_pkg::*;
#(
  parameter int unsigned    PIPE_DEPTH   = PIPE_DEPTH_DEF,
  parameter logic [31:0]    NONCE_START  = 32'h0,
  parameter logic [31:0]    NONCE_STRIDE = 32'h1,
  parameter logic [31:0]    NONCE_LAST   = 32'hFFFF_FFFF,
  parameter int             FIFO_DEPTH   = 4
) (
  input  logic               hash_clk,
  input  logic               reset_n,
  input  logic               work_valid,
  output logic               work_ready,
  input  logic [255:0]       work_midstate,
  input  logic [95:0]        work_data,
  input  logic [ID_W-1:0]    work_id,
  output logic [255:0]       core_midstate,
  output logic [95:0]        core_data,
  output logic [NONCE_W-1:0] core_nonce,
  input  logic               core_match,
  input  logic [NONCE_W-1:0] core_golden,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [NONCE_W-1:0] res_nonce,
  output logic [ID_W-1:0]    res_id,
  output logic               busy,
  output logic               exhausted,
  output logic [CNT_W-1:0]   hash_count,
  output logic [DROP_W-1:0]  drop_count
);
  localparam int SW = $clog2(PIPE_DEPTH + 1);
  logic [1:0]      r_rst_sync;
  logic            w_rst_n;
  state_e          r_state;
  logic [SW-1:0]   r_since, r_drain;
  logic [ID_W-1:0] r_cur_id, r_prev_id, w_tag;
  logic            r_switched;
  logic            w_since_full, w_load, w_last, w_push, w_full, w_drop;
  logic [RES_W-1:0] w_res_data;
  // Assertion propagates immediately; release is retimed through two flops.
  always_ff @(posedge hash_clk or negedge reset_n) begin
    if (!reset_n) r_rst_sync <= '0;
    else          r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n      = r_rst_sync[1];
  assign w_since_full = r_since == SW'(PIPE_DEPTH);
  assign work_ready   = (r_state == ST_IDLE) | ((r_state == ST_RUN) & w_since_full);
  assign w_load       = work_valid & work_ready;
  assign w_last       = (r_state == ST_RUN) & (core_nonce == NONCE_LAST);
  assign exhausted    = w_last;
  assign busy         = r_state != ST_IDLE;
  assign w_push       = core_match & busy;
  // Until the pipe has flushed after a RUN-to-RUN switch, matches belong to the old work.
  assign w_tag        = (r_switched & ~w_since_full) ? r_prev_id : r_cur_id;
  assign w_drop       = w_push & w_full & ~(res_valid & res_ready);
  always_ff @(posedge hash_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state       <= ST_IDLE;
      r_since       <= '0;
      r_drain       <= '0;
      r_cur_id      <= '0;
      r_prev_id     <= '0;
      r_switched    <= 1'b0;
      core_midstate <= '0;
      core_data     <= '0;
      core_nonce    <= '0;
      hash_count    <= '0;
      drop_count    <= '0;
    end else begin
      r_since <= w_load ? '0 : (w_since_full ? r_since : r_since + 1'b1);
      if (r_state == ST_RUN) hash_count <= hash_count + 1'b1;
      if (w_drop && drop_count != '1) drop_count <= drop_count + 1'b1;
      if (w_load) begin
        core_midstate <= work_midstate;
        core_data     <= work_data;
        core_nonce    <= NONCE_START;
        r_cur_id      <= work_id;
        r_state       <= ST_RUN;
        r_switched    <= r_state == ST_RUN;
        if (r_state == ST_RUN) r_prev_id <= r_cur_id;
      end else if (w_last) begin
        r_state <= ST_DRAIN;
        r_drain <= '0;
      end else if (r_state == ST_RUN) begin
        core_nonce <= core_nonce + NONCE_STRIDE;
      end else if (r_state == ST_DRAIN) begin
        r_drain <= r_drain + 1'b1;
        if (r_drain == SW'(PIPE_DEPTH - 1)) r_state <= ST_IDLE;
      end
    end
  end
  hash_result_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(RES_W)
  ) u_fifo (
    .clk    (hash_clk),
    .rst_n  (w_rst_n),
    .i_push (w_push),
    .i_data ({core_golden, w_tag}),
    .i_pop  (res_ready),
    .o_valid(res_valid),
    .o_full (w_full),
    .o_data (w_res_data)
  );
  assign {res_nonce, res_id} = w_res_data;
endmodule

// File: tb/tb_hash_work_sched.sv
// tb_hash_work_sched: randomized scoreboard bench against a behavioural model of the scheduler.
module tb_hash_work_sched;
  localparam int          PD     = 130;
  localparam int          FD     = 4;
  localparam logic [31:0] START  = 32'h0;
  localparam logic [31:0] STRIDE = 32'h1;
  localparam logic [31:0] LAST   = 32'h3FF;
  logic         hash_clk, reset_n, work_valid, work_ready, core_match, res_valid, res_ready;
  logic         busy, exhausted;
  logic [255:0] work_midstate, core_midstate;
  logic [95:0]  work_data, core_data;
  logic [7:0]   work_id, res_id, drop_count;
  logic [31:0]  core_nonce, core_golden, res_nonce, hash_count;
  hash_work_sched #(
    .PIPE_DEPTH(PD), .NONCE_START(START), .NONCE_STRIDE(STRIDE),
    .NONCE_LAST(LAST), .FIFO_DEPTH(FD)
  ) dut (
    .hash_clk(hash_clk), .reset_n(reset_n), .work_valid(work_valid), .work_ready(work_ready),
    .work_midstate(work_midstate), .work_data(work_data), .work_id(work_id),
    .core_midstate(core_midstate), .core_data(core_data), .core_nonce(core_nonce),
    .core_match(core_match), .core_golden(core_golden), .res_valid(res_valid),
    .res_ready(res_ready), .res_nonce(res_nonce), .res_id(res_id), .busy(busy),
    .exhausted(exhausted), .hash_count(hash_count), .drop_count(drop_count)
  );
  initial begin
    hash_clk = 0;
    forever #5 hash_clk = ~hash_clk;
  end
  int n_cmp = 0, n_bad = 0;
  // Behavioural model: 0=idle 1=run 2=drain; nonce derived from count of issues since load.
  int           m_st, m_since, m_dleft, m_occ, m_drop;
  logic [31:0]  m_k, m_hash;
  logic [7:0]   m_cur, m_prev;
  bit           m_sw;
  logic [255:0] m_mid;
  logic [95:0]  m_dat;
  logic [39:0]  sb[$];
  task automatic chk(string nm, logic [255:0] act, logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic logic [31:0] m_nonce();
    return START + STRIDE * m_k;
  endfunction
  task automatic model_reset();
    m_st = 0; m_since = 0; m_dleft = 0; m_occ = 0; m_drop = 0;
    m_k = 0; m_hash = 0; m_cur = 0; m_prev = 0; m_sw = 0; m_mid = 0; m_dat = 0;
    sb.delete();
  endtask
  task automatic model_edge();
    bit hs, pop, push;
    logic [7:0] tag;
    hs   = work_valid && (m_st == 0 || (m_st == 1 && m_since == PD));
    pop  = res_ready && m_occ > 0;
    push = core_match && m_st != 0;
    tag  = (m_sw && m_since < PD) ? m_prev : m_cur;
    if (push) begin
      if (m_occ < FD || pop) begin
        sb.push_back({core_golden, tag});
        m_occ++;
      end else if (m_drop < 255) m_drop++;
    end
    if (pop) m_occ--;
    if (m_st == 1) m_hash++;
    m_since = hs ? 0 : (m_since < PD ? m_since + 1 : PD);
    if (hs) begin
      m_sw = (m_st == 1);
      if (m_st == 1) m_prev = m_cur;
      m_cur = work_id; m_mid = work_midstate; m_dat = work_data; m_k = 0; m_st = 1;
    end else if (m_st == 1 && m_nonce() == LAST) begin
      m_st = 2; m_dleft = PD;
    end else if (m_st == 1) m_k++;
    else if (m_st == 2) begin
      m_dleft--;
      if (m_dleft == 0) m_st = 0;
    end
  endtask
  task automatic check_outputs();
    chk("core_nonce", core_nonce, m_nonce());
    chk("busy", busy, m_st != 0);
    chk("work_ready", work_ready, m_st == 0 || (m_st == 1 && m_since == PD));
    chk("exhausted", exhausted, m_st == 1 && m_nonce() == LAST);
    chk("hash_count", hash_count, m_hash);
    chk("drop_count", drop_count, 8'(m_drop));
    chk("res_valid", res_valid, m_occ > 0);
    chk("core_midstate", core_midstate, m_mid);
    chk("core_data", core_data, m_dat);
  endtask
  task automatic check_reset();
    chk("rst_midstate", core_midstate, 0);
    chk("rst_data", core_data, 0);
    chk("rst_nonce", core_nonce, 0);
    chk("rst_hash_count", hash_count, 0);
    chk("rst_drop_count", drop_count, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_nonce", res_nonce, 0);
    chk("rst_res_id", res_id, 0);
    chk("rst_busy", busy, 0);
    chk("rst_exhausted", exhausted, 0);
    chk("rst_work_ready", work_ready, 1);
  endtask
  task automatic rand_inputs(int pv, int pm, int pr);
    work_valid = $urandom_range(99) < pv;
    work_id    = 8'($urandom);
    for (int i = 0; i < 8; i++) work_midstate[i*32 +: 32] = $urandom;
    for (int i = 0; i < 3; i++) work_data[i*32 +: 32] = $urandom;
    core_match  = $urandom_range(99) < pm;
    core_golden = $urandom;
    res_ready   = $urandom_range(99) < pr;
  endtask
  task automatic run(int n, int pv, int pm, int pr);
    for (int c = 0; c < n; c++) begin
      @(posedge hash_clk);
      model_edge();
      #1;
      check_outputs();
      rand_inputs(pv, pm, pr);
    end
  endtask
  task automatic load(logic [7:0] id);
    rand_inputs(0, 0, 100);
    work_valid = 1;
    work_id    = id;
    run(1, 0, 0, 100);
  endtask
  task automatic match(logic [31:0] g, int settle);
    core_match  = 1;
    core_golden = g;
    run(1, 0, 0, 100);
    run(settle, 0, 0, 100);
  endtask
  always @(negedge hash_clk) begin
    if (res_valid) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_result: got %0h expected none at %0t", {res_nonce, res_id}, $time);
      end else begin
        chk("res_head", {res_nonce, res_id}, sb[0]);
        if (res_ready) void'(sb.pop_front());
      end
    end
  end
  initial begin
    reset_n = 0;
    work_valid = 0; work_id = 0; work_midstate = 0; work_data = 0;
    core_match = 0; core_golden = 0; res_ready = 0;
    model_reset();
    #12;
    check_reset();
    @(posedge hash_clk);
    #1 reset_n = 1;
    run(4, 0, 0, 0);
    load(8'd5);
    run(200, 0, 0, 100);
    match(32'h1234, 3);
    load(8'd9);
    run(48, 0, 0, 100);
    match(32'h5555, 2);
    run(90, 0, 0, 100);
    match(32'h9999, 2);
    run(1300, 0, 5, 70);
    load(8'h3C);
    run(140, 0, 0, 100);
    rand_inputs(0, 100, 0);
    run(6, 0, 100, 0);
    run(5, 0, 100, 100);
    run(10, 0, 0, 100);
    run(3000, 4, 10, 50);
    load(8'hA7);
    run(60, 0, 20, 0);
    #3 reset_n = 0;
    work_valid = 0; core_match = 0; res_ready = 0;
    #1;
    check_reset();
    model_reset();
    @(posedge hash_clk);
    @(posedge hash_clk);
    #1 reset_n = 1;
    run(4, 0, 0, 0);
    run(400, 5, 10, 50);
    rand_inputs(0, 0, 100);
    run(20, 0, 0, 100);
    chk("scoreboard_empty", 32'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
